divider_seq: RTL and testbench

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/divider_seq.sv | 201 ++++++++++++++++++++
 tb/tb_divider_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// divider_seq: sequential signed integer divider (non-restoring, one step per cycle).
//
// The quotient is truncated toward zero. A division takes WIDTH+3 cycles from the
// start edge to the result-valid pulse. Divide-by-zero and the single overflow case
// (most-negative / -1) finish early with data_exception set.
//
// Parameters
//   WIDTH           operand/result width, 8..32, even (default 32)
//
// Optional build macro
//   DIV_REMAINDER_EN  adds output data_remainder (signed, sign follows dividend)
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous active-high reset, takes priority over ctrl_DIV
//   ctrl_DIV        start pulse; operands are sampled on the same edge, any state
//   data_operandA   signed dividend
//   data_operandB   signed divisor
//   data_result     signed quotient, held until the next start
//   data_remainder  signed remainder (DIV_REMAINDER_EN only)
//   data_exception  divide-by-zero / overflow flag, valid with data_resultRDY
//   data_resultRDY  one-cycle result-valid pulse
//   busy            high in LOAD, RUN and FIX
//   iter_           current RUN iteration, for debug
module divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [5:0]       iter_
);

  // Magnitudes are WIDTH+1 bits so |-2^(WIDTH-1)| does not wrap.
  localparam int DW = WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state;

  logic [DW-1:0]    mag_a;
  logic [DW-1:0]    mag_b;
  logic             sign_a;
  logic             sign_b;
  logic             sign_q;

  // Partial remainder carries one extra bit as its sign (non-restoring).
  logic [DW:0]      rem;
  // Holds the unshifted dividend bits at the top, collects quotient bits at the bottom.
  logic [WIDTH-1:0] quo;

  logic [DW-1:0]    ext_a;
  logic [DW-1:0]    ext_b;
  logic [DW:0]      shifted;
  logic [DW:0]      b_ext;
  logic [DW:0]      rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] quo_fix;
  logic             overflow_case;

  always_comb begin
    ext_a    = {data_operandA[WIDTH-1], data_operandA};
    ext_b    = {data_operandB[WIDTH-1], data_operandB};

    // One non-restoring step: shift in the next dividend bit, then subtract the
    // divisor if the remainder is non-negative, add it back otherwise.
    shifted  = {rem[DW-1:0], quo[WIDTH-1]};
    b_ext    = {1'b0, mag_b};
    rem_step = rem[DW] ? (shifted + b_ext) : (shifted - b_ext);
    quo_step = {quo[WIDTH-2:0], ~rem_step[DW]};

    quo_fix  = sign_q ? -quo : quo;

    overflow_case = sign_a && (mag_a == {1'b0, 1'b1, {(WIDTH-1){1'b0}}})
                 && sign_b && (mag_b == DW'(1));
  end

`ifdef DIV_REMAINDER_EN
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] rem_out;

  always_comb begin
    // A negative final remainder is restored by one add; the result is below |B|
    // and therefore fits in WIDTH bits.
    rem_fix = WIDTH'(rem[DW] ? (rem + b_ext) : rem);
    rem_out = sign_a ? -rem_fix : rem_fix;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
      iter_          <= '0;
      mag_a          <= '0;
      mag_b          <= '0;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      sign_q         <= 1'b0;
      rem            <= '0;
      quo            <= '0;
`ifdef DIV_REMAINDER_EN
      data_remainder <= '0;
`endif
    end else if (ctrl_DIV) begin
      // A start in any state discards whatever was in flight.
      state          <= LOAD;
      mag_a          <= data_operandA[WIDTH-1] ? -ext_a : ext_a;
      mag_b          <= data_operandB[WIDTH-1] ? -ext_b : ext_b;
      sign_a         <= data_operandA[WIDTH-1];
      sign_b         <= data_operandB[WIDTH-1];
      sign_q         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b1;
      iter_          <= '0;
`ifdef DIV_REMAINDER_EN
      data_remainder <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
        end

        LOAD: begin
          rem <= '0;
          quo <= mag_a[WIDTH-1:0];
          if (mag_b == '0) begin
            state          <= DONE;
            data_result    <= '0;
            data_exception <= 1'b1;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
          end else if (overflow_case) begin
            state          <= DONE;
            data_result    <= {1'b1, {(WIDTH-1){1'b0}}};
            data_exception <= 1'b1;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
          end else begin
            state <= RUN;
          end
        end

        RUN: begin
          rem <= rem_step;
          quo <= quo_step;
          if (iter_ == 6'(WIDTH - 1)) begin
            state <= FIX;
          end else begin
            iter_ <= iter_ + 6'd1;
          end
        end

        FIX: begin
          state          <= DONE;
          data_result    <= quo_fix;
          data_exception <= 1'b0;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
`ifdef DIV_REMAINDER_EN
          data_remainder <= rem_out;
`endif
        end

        DONE: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
        end

        default: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: self-checking bench for divider_seq (WIDTH=32).
// Directed cases, abort/reset scenarios and randomized operands are compared
// against an arithmetic reference computed with 64-bit signed division.
module tb_divider_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         ctrl_DIV;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;
  logic [5:0]   iter_;
`ifdef DIV_REMAINDER_EN
  logic [W-1:0] data_remainder;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  divider_seq #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
`ifdef DIV_REMAINDER_EN
    .data_remainder (data_remainder),
`endif
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .iter_          (iter_)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic, truncating division, remainder follows dividend.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic exc, output int lat);
    longint sa, sb, lmin;
    sa   = $signed(a);
    sb   = $signed(b);
    lmin = -(longint'(1) <<< (W - 1));
    if (sb == 0) begin
      q = '0; r = '0; exc = 1'b1; lat = 2;
    end else if (sa == lmin && sb == -1) begin
      q = a;  r = '0; exc = 1'b1; lat = 2;
    end else begin
      q = W'(sa / sb); r = W'(sa % sb); exc = 1'b0; lat = W + 3;
    end
  endfunction

  // Advance to one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with a start pulse; returns in cycle E0+1.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    tick();
    ctrl_DIV      = 1'b0;
  endtask

  // Called in cycle E0+1; watches until a few cycles past the expected RDY.
  task automatic observe(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic exc, input int lat);
    int rdy_cnt = 0;
    int rdy_at = 0;
    int busy_bad = 0;
    logic [W-1:0] res_at_rdy = '0;
    logic exc_at_rdy = 1'b0;
    check({tag, "_clr_res"}, data_result, 0);
    check({tag, "_clr_exc"}, data_exception, 0);
    for (int k = 1; k <= lat + 3; k++) begin
      if (k > 1) tick();
      if (data_resultRDY) begin
        rdy_cnt++;
        rdy_at     = k;
        res_at_rdy = data_result;
        exc_at_rdy = data_exception;
      end
      if (busy !== (k < lat)) busy_bad++;
    end
    check({tag, "_rdy_cnt"}, rdy_cnt, 1);
    check({tag, "_rdy_at"}, rdy_at, lat);
    check({tag, "_res"}, res_at_rdy, q);
    check({tag, "_exc"}, exc_at_rdy, exc);
    check({tag, "_hold"}, data_result, q);
    check({tag, "_busy"}, busy_bad, 0);
`ifdef DIV_REMAINDER_EN
    check({tag, "_rem"}, data_remainder, r);
`else
    if (r === 'x) $display("unexpected unknown remainder in %s", tag);
`endif
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] q, r;
    logic exc;
    int lat;
    ref_div(a, b, q, r, exc, lat);
    start(a, b);
    observe(tag, q, r, exc, lat);
  endtask

  int dir_a[11] = '{100, -100, 100, 5, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 3,
                    32'h80000000, 32'h80000000, -7};
  int dir_b[11] = '{7, 7, -7, 0, 32'hFFFFFFFF, 1, 2, 5, 1, 32'h80000000, 32'h80000000};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] q, r;
    logic exc;
    int lat;
    int n;
    int stray;

    reset = 1'b1;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    tick();
    tick();
    check("rst_res", data_result, 0);
    check("rst_exc", data_exception, 0);
    check("rst_rdy", data_resultRDY, 0);
    check("rst_busy", busy, 0);
    check("rst_iter", iter_, 0);

    // Start on the very first edge after reset release.
    reset = 1'b0;
    for (int i = 0; i < 11; i++) run_div(dir_a[i], dir_b[i], $sformatf("dir%0d", i));

    // Restart mid-RUN: the first division must never signal ready.
    start(1000, 10);
    n = 0;
    stray = 0;
    while (!(iter_ == 6'd10 && busy) && n < 60) begin
      tick();
      n++;
      if (data_resultRDY) stray++;
    end
    check("abort_reach_iter10", n < 60, 1);
    ref_div(9, 3, q, r, exc, lat);
    start(9, 3);
    check("abort_first_rdy", stray, 0);
    observe("abort", q, r, exc, lat);

    // Reset mid-RUN discards the operation.
    start(50, 5);
    n = 0;
    stray = 0;
    while (!(iter_ == 6'd20 && busy) && n < 60) begin
      tick();
      n++;
    end
    check("rst_reach_iter20", n < 60, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_res", data_result, 0);
    check("midrst_rdy", data_resultRDY, 0);
    check("midrst_iter", iter_, 0);
    for (int k = 0; k < 45; k++) begin
      if (data_resultRDY) stray++;
      tick();
    end
    check("midrst_no_rdy", stray, 0);
    run_div(50, 5, "after_rst");

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] a, b;
      int sel;
      sel = $urandom_range(0, 4);
      a = $urandom;
      b = $urandom;
      case (sel)
        1: b = (($urandom_range(0, 1) == 1) ? -1 : 1) * int'($urandom_range(1, 40));
        2: b = '0;
        3: begin a = 32'h80000000; b = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h1; end
        default: ;
      endcase
      run_div(a, b, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
